threshold_tuner: RTL and testbench

THRESHOLD_TUNER -- requirements
Module: threshold_tuner

---
 rtl/threshold_pkg.sv | 13 +
 rtl/threshold_tuner_if.sv | 18 +
 rtl/mask_counter.sv | 24 ++
 rtl/threshold_tuner.sv | 123 ++++++++++++
 tb/tb_threshold_tuner.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/threshold_pkg.sv
// rtl/threshold_pkg.sv - shared types and defaults for the threshold tuner
package threshold_pkg;

    localparam int DEF_COUNT_W = 17;
    localparam int DEF_STEP    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2
    } tuner_state_t;

endpackage

// File: rtl/threshold_tuner_if.sv
// rtl/threshold_tuner_if.sv - host bound-write handshake bundle
interface threshold_tuner_if;
    logic       manual_valid;
    logic       manual_ready;
    logic [7:0] manual_lower;
    logic [7:0] manual_upper;
    logic       cfg_err;

    modport master (
        output manual_valid, manual_lower, manual_upper,
        input  manual_ready, cfg_err
    );

    modport slave (
        input  manual_valid, manual_lower, manual_upper,
        output manual_ready, cfg_err
    );
endinterface

// File: rtl/mask_counter.sv
// rtl/mask_counter.sv - saturating per-frame mask hit counter
module mask_counter
    import threshold_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clear,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/threshold_tuner.sv
// rtl/threshold_tuner.sv - per-frame automatic lower-bound tracking with host override
module threshold_tuner
    import threshold_pkg::*;
#(
    parameter int         COUNT_W    = DEF_COUNT_W,
    parameter int         STEP       = DEF_STEP,
    parameter logic [7:0] INIT_LOWER = 8'd127,
    parameter logic [7:0] INIT_UPPER = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mask,
    input  logic               mask_valid,
    input  logic               frame_done,
    input  logic               auto_en,
    input  logic [COUNT_W-1:0] target_min,
    input  logic [COUNT_W-1:0] target_max,
    threshold_tuner_if.slave   cfg,
    output logic [7:0]         lower_bound,
    output logic [7:0]         upper_bound,
    output logic [COUNT_W-1:0] hit_count,
    output logic               busy
);

    tuner_state_t       state;
    logic               pending;
    logic [7:0]         next_lower;
    logic [7:0]         eval_lower;
    logic [8:0]         raised;
    logic               inc;
    logic               hs;
    logic               bounds_ok;
    logic [COUNT_W-1:0] acc;
    logic [COUNT_W-1:0] acc_final;

    assign inc       = mask_valid & mask;
    assign hs        = cfg.manual_valid & cfg.manual_ready;
    assign bounds_ok = cfg.manual_lower < cfg.manual_upper;

    // The last pixel's hit must land in hit_count even though the counter clears on that edge.
    assign acc_final = (inc && (acc != '1)) ? acc + COUNT_W'(1) : acc;

    mask_counter #(.COUNT_W(COUNT_W)) u_mask_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .clear (frame_done),
        .count (acc)
    );

    always_comb begin
        eval_lower = lower_bound;
        raised     = {1'b0, lower_bound} + 9'(STEP);
        if (auto_en && (target_min <= target_max)) begin
            if (hit_count > target_max) begin
                eval_lower = (raised > ({1'b0, upper_bound} - 9'd1)) ? upper_bound - 8'd1
                                                                     : raised[7:0];
            end else if (hit_count < target_min) begin
                eval_lower = ({1'b0, lower_bound} < 9'(STEP)) ? 8'd0
                                                              : lower_bound - 8'(STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pending          <= 1'b0;
            hit_count        <= '0;
            lower_bound      <= INIT_LOWER;
            upper_bound      <= INIT_UPPER;
            next_lower       <= INIT_LOWER;
            busy             <= 1'b0;
            cfg.manual_ready <= 1'b0;
            cfg.cfg_err      <= 1'b0;
        end else begin
            cfg.cfg_err <= hs && !bounds_ok;
            if (hs && bounds_ok) begin
                lower_bound <= cfg.manual_lower;
                upper_bound <= cfg.manual_upper;
            end
            if (frame_done) begin
                hit_count <= acc_final;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_done || pending) begin
                        state            <= ST_EVAL;
                        pending          <= 1'b0;
                        busy             <= 1'b1;
                        cfg.manual_ready <= 1'b0;
                    end else begin
                        busy             <= 1'b0;
                        cfg.manual_ready <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    next_lower <= eval_lower;
                    state      <= ST_UPDATE;
                    if (frame_done) begin
                        pending <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    lower_bound      <= next_lower;
                    state            <= ST_IDLE;
                    busy             <= 1'b0;
                    cfg.manual_ready <= 1'b1;
                    if (frame_done) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    busy             <= 1'b0;
                    cfg.manual_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_tuner.sv
// tb/tb_threshold_tuner.sv - scoreboard bench for threshold_tuner
module tb_threshold_tuner;
    localparam int CW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          mask;
    logic          mask_valid;
    logic          frame_done;
    logic          auto_en;
    logic [CW-1:0] target_min;
    logic [CW-1:0] target_max;
    logic [7:0]    lower_bound;
    logic [7:0]    upper_bound;
    logic [CW-1:0] hit_count;
    logic          busy;

    threshold_tuner_if cfg_if();

    threshold_tuner dut (
        .clk         (clk),
        .rst         (rst),
        .mask        (mask),
        .mask_valid  (mask_valid),
        .frame_done  (frame_done),
        .auto_en     (auto_en),
        .target_min  (target_min),
        .target_max  (target_max),
        .cfg         (cfg_if),
        .lower_bound (lower_bound),
        .upper_bound (upper_bound),
        .hit_count   (hit_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hits;
        int lower;
        int upper;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_lower;
    int   mdl_upper;
    int   lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_next(int hits, int lo, int up, int tmin, int tmax, bit ae);
        if (!ae || tmin > tmax) return lo;
        if (hits > tmax) return (lo + 4 > up - 1) ? up - 1 : lo + 4;
        if (hits < tmin) return (lo < 4) ? 0 : lo - 4;
        return lo;
    endfunction

    task automatic expect_frame(input int hits, input int obs_hits);
        exp_t e;
        e.hits    = obs_hits;
        e.lower   = model_next(hits, mdl_lower, mdl_upper, int'(target_min), int'(target_max), auto_en);
        e.upper   = mdl_upper;
        mdl_lower = e.lower;
        sb.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("hit_count", 32'(hit_count), e.hits);
            check("lower_bound", 32'(lower_bound), e.lower);
            check("upper_bound", 32'(upper_bound), e.upper);
        end
    endtask

    task automatic wait_update(output int n);
        int n0 = 0;
        n = 0;
        while (!busy && n0 < 20) begin
            tick();
            n0++;
        end
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("update_done", 32'(n0 < 20 && !busy), 32'd1);
        sb_compare();
    endtask

    task automatic drive_frame(input int hits, input int total, input bit mw = 1'b0,
                               input int mlo = 0, input int mup = 0);
        for (int i = 0; i < total; i++) begin
            mask_valid = 1'b1;
            mask       = (i < hits);
            frame_done = (i == total - 1);
            if (mw && i == total - 1) begin
                check("ready_at_fd", 32'(cfg_if.manual_ready), 32'd1);
                cfg_if.manual_valid = 1'b1;
                cfg_if.manual_lower = 8'(mlo);
                cfg_if.manual_upper = 8'(mup);
            end
            tick();
        end
        mask_valid          = 1'b0;
        mask                = 1'b0;
        frame_done          = 1'b0;
        cfg_if.manual_valid = 1'b0;
    endtask

    task automatic manual_write(input int lo, input int up);
        int n = 0;
        while (!cfg_if.manual_ready && n < 20) begin
            tick();
            n++;
        end
        check("mw_ready", 32'(cfg_if.manual_ready), 32'd1);
        cfg_if.manual_valid = 1'b1;
        cfg_if.manual_lower = 8'(lo);
        cfg_if.manual_upper = 8'(up);
        tick();
        cfg_if.manual_valid = 1'b0;
        if (lo < up) begin
            mdl_lower = lo;
            mdl_upper = up;
        end
        check("cfg_err_pulse", 32'(cfg_if.cfg_err), 32'(lo >= up));
        check("mw_lower", 32'(lower_bound), mdl_lower);
        check("mw_upper", 32'(upper_bound), mdl_upper);
        tick();
        check("cfg_err_clear", 32'(cfg_if.cfg_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        mask                = 1'b0;
        mask_valid          = 1'b0;
        frame_done          = 1'b0;
        auto_en             = 1'b0;
        target_min          = '0;
        target_max          = '0;
        cfg_if.manual_valid = 1'b0;
        cfg_if.manual_lower = 8'd0;
        cfg_if.manual_upper = 8'd0;
        mdl_lower           = 127;
        mdl_upper           = 255;

        repeat (3) tick();
        check("ready_in_rst", 32'(cfg_if.manual_ready), 32'd0);
        check("busy_in_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_lower", 32'(lower_bound), 32'd127);
        check("rst_upper", 32'(upper_bound), 32'd255);
        check("rst_hit", 32'(hit_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_if.manual_ready), 32'd1);

        // Above window: raise by STEP with 3-edge latency.
        auto_en    = 1'b1;
        target_min = 17'd100;
        target_max = 17'd200;
        expect_frame(300, 300);
        drive_frame(300, 320);
        check("busy_eval", 32'(busy), 32'd1);
        check("ready_eval", 32'(cfg_if.manual_ready), 32'd0);
        wait_update(lat);
        check("latency", 32'(lat + 1), 32'd3);

        // Below window near zero: clamp, no wrap.
        manual_write(2, 255);
        target_min = 17'd10;
        expect_frame(0, 0);
        drive_frame(0, 5);
        wait_update(lat);
        expect_frame(0, 0);
        drive_frame(0, 5);
        wait_update(lat);

        // Near the top: cap at upper-1.
        manual_write(253, 255);
        target_min = 17'd100;
        expect_frame(300, 300);
        drive_frame(300, 320);
        wait_update(lat);
        expect_frame(300, 300);
        drive_frame(300, 320);
        wait_update(lat);

        // Rejected write, then a write held across EVAL/UPDATE.
        manual_write(200, 100);
        expect_frame(150, 150);
        drive_frame(150, 160);
        cfg_if.manual_valid = 1'b1;
        cfg_if.manual_lower = 8'd60;
        cfg_if.manual_upper = 8'd160;
        check("hold_ready_eval", 32'(cfg_if.manual_ready), 32'd0);
        tick();
        check("hold_ready_upd", 32'(cfg_if.manual_ready), 32'd0);
        check("hold_upper_upd", 32'(upper_bound), 32'd255);
        tick();
        sb_compare();
        check("hold_ready_idle", 32'(cfg_if.manual_ready), 32'd1);
        tick();
        cfg_if.manual_valid = 1'b0;
        mdl_lower = 60;
        mdl_upper = 160;
        check("held_lower", 32'(lower_bound), 32'd60);
        check("held_upper", 32'(upper_bound), 32'd160);

        // frame_done during EVAL is remembered and re-evaluated.
        expect_frame(300, 1);
        expect_frame(1, 1);
        drive_frame(300, 320);
        mask_valid = 1'b1;
        mask       = 1'b1;
        frame_done = 1'b1;
        tick();
        mask_valid = 1'b0;
        mask       = 1'b0;
        frame_done = 1'b0;
        wait_update(lat);
        wait_update(lat);

        // Inverted window and auto disabled both hold.
        target_min = 17'd300;
        target_max = 17'd100;
        expect_frame(0, 0);
        drive_frame(0, 5);
        wait_update(lat);
        auto_en    = 1'b0;
        target_min = 17'd100;
        target_max = 17'd200;
        expect_frame(300, 300);
        drive_frame(300, 320);
        wait_update(lat);
        auto_en = 1'b1;

        // Manual write coinciding with frame_done; EVAL sees the new bounds.
        target_min = 17'd20;
        mdl_lower  = 50;
        mdl_upper  = 150;
        expect_frame(10, 10);
        drive_frame(10, 12, 1'b1, 50, 150);
        check("same_cycle_upper", 32'(upper_bound), 32'd150);
        check("same_cycle_lower", 32'(lower_bound), 32'd50);
        wait_update(lat);

        // Reset in UPDATE abandons the adjustment.
        target_min = 17'd100;
        drive_frame(300, 320);
        tick();
        check("busy_update", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_lower = 127;
        mdl_upper = 255;
        check("rst_upd_lower", 32'(lower_bound), 32'd127);
        check("rst_upd_upper", 32'(upper_bound), 32'd255);
        check("rst_upd_hit", 32'(hit_count), 32'd0);
        tick();
        tick();
        check("rst_upd_no_late", 32'(lower_bound), 32'd127);
        check("rst_upd_busy", 32'(busy), 32'd0);

        // Hits from a partial pre-reset frame are discarded.
        for (int i = 0; i < 90; i++) begin
            mask_valid = 1'b1;
            mask       = 1'b1;
            tick();
        end
        mask_valid = 1'b0;
        mask       = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        expect_frame(120, 120);
        drive_frame(120, 130);
        wait_update(lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
